// File: rtl/neuron_input_loader.sv
// Serial-to-parallel front end for the 49-input neuron. It collects a framed sample stream
// into a vector register and tracks the neuron's fixed latency with a valid delay line.
module neuron_input_loader #(
  parameter int N_INPUTS       = 49,
  parameter int DATA_W         = 32,
  parameter int NEURON_LATENCY = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [DATA_W-1:0]        s_data,
  input  logic                            s_valid,
  input  logic                            s_last,
  output logic                            s_ready,
  output logic [N_INPUTS-1:0][DATA_W-1:0] vec_out,
  output logic                            vec_valid,
  output logic                            result_valid,
  output logic                            frame_err
);

  localparam int               IDX_W    = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  logic [IDX_W-1:0]                 idx;
  logic [N_INPUTS-2:0][DATA_W-1:0]  shadow;
  logic [NEURON_LATENCY-1:0]        vld_pipe;
  logic                             accept;
  logic                             at_end;
  logic                             commit;
  logic                             discard;

  always_comb begin
    accept  = s_valid && s_ready;
    at_end  = (idx == IDX_LAST);
    commit  = accept && at_end && s_last;
    // s_last must coincide exactly with the final slot; any other pairing is malformed
    discard = accept && (s_last != at_end);
  end

  // Stage p0: fill index, ready and frame strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      s_ready   <= 1'b0;
      vec_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s_ready   <= 1'b1;
      vec_valid <= commit;
      frame_err <= discard;
      if (accept) begin
        if (at_end || s_last) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Stage p0: shadow fill and vector commit; the final sample bypasses the shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      vec_out <= '0;
    end else begin
      if (accept && !at_end) begin
        shadow[idx] <= s_data;
      end
      if (commit) begin
        vec_out <= {s_data, shadow};
      end
    end
  end

  // Stages p1..pL: vec_valid delayed by the neuron latency
  generate
    if (NEURON_LATENCY > 1) begin : g_dly_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe <= {vld_pipe[NEURON_LATENCY-2:0], vec_valid};
        end
      end
    end else begin : g_dly_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe <= vec_valid;
        end
      end
    end
  endgenerate

  assign result_valid = vld_pipe[NEURON_LATENCY-1];

endmodule

// File: tb/tb_neuron_input_loader.sv
// Directed bench for neuron_input_loader: frame-level model with per-cycle compare,
// plus hand-computed literal expectations for each scenario.
module tb_neuron_input_loader;
  localparam int N   = 49;
  localparam int W   = 32;
  localparam int LAT = 6;

  logic                 clk;
  logic                 rst;
  logic signed [W-1:0]  s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;
  logic [N-1:0][W-1:0]  vec_out;
  logic                 vec_valid;
  logic                 result_valid;
  logic                 frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic               m_ready = 1'b0;
  logic               m_vv    = 1'b0;
  logic               m_fe    = 1'b0;
  logic               m_rv    = 1'b0;
  int                 m_cnt   = 0;
  logic [W-1:0]       m_frame [N];
  logic [N-1:0][W-1:0] m_vec  = '0;
  int                 rv_due[$];

  int vv_q[$];
  int rv_q[$];
  int fe_cnt = 0;
  int t_last;

  neuron_input_loader #(.N_INPUTS(N), .DATA_W(W), .NEURON_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .vec_out(vec_out), .vec_valid(vec_valid),
    .result_valid(result_valid), .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_vec();
    int first_bad;
    n_checks++;
    if (vec_out === m_vec) n_pass++;
    else begin
      first_bad = -1;
      for (int k = N - 1; k >= 0; k--) if (vec_out[k] !== m_vec[k]) first_bad = k;
      $display("FAIL vec_out[%0d]: got %0h expected %0h (cycle %0d)",
               first_bad, vec_out[first_bad], m_vec[first_bad], cyc);
    end
  endtask

  // Frame-level reference: counts accepted samples, decides commit/discard per frame
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b0; m_cnt = 0; m_vec = '0;
      m_vv = 1'b0; m_fe = 1'b0; m_rv = 1'b0;
      rv_due.delete();
    end else begin
      cyc++;
      m_vv = 1'b0; m_fe = 1'b0; m_rv = 1'b0;
      if (m_ready && s_valid) begin
        m_frame[m_cnt] = s_data;
        if (m_cnt == N - 1 && s_last) begin
          for (int k = 0; k < N; k++) m_vec[k] = m_frame[k];
          m_vv = 1'b1;
          rv_due.push_back(cyc + LAT);
          m_cnt = 0;
        end else if (s_last || m_cnt == N - 1) begin
          m_fe = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (rv_due.size() > 0 && rv_due[0] == cyc) begin
        m_rv = 1'b1;
        void'(rv_due.pop_front());
      end
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("s_ready", s_ready, m_ready);
      chk("vec_valid", vec_valid, m_vv);
      chk("frame_err", frame_err, m_fe);
      chk("result_valid", result_valid, m_rv);
      chk("strobe_exclusive", vec_valid && frame_err, 1'b0);
      chk_vec();
      if (vec_valid) vv_q.push_back(cyc);
      if (result_valid) rv_q.push_back(cyc);
      if (frame_err) fe_cnt++;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    vv_q.delete(); rv_q.delete(); fe_cnt = 0;
  endtask

  function automatic int q0(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int qdiff(input int q[$]);
    return (q.size() > 1) ? q[1] - q[0] : -1;
  endfunction

  task automatic do_reset(input int n);
    #2 rst = 1'b1;
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_vec_valid", vec_valid, 1'b0);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_vec_zero", vec_out == '0, 1'b1);
    repeat (n) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("init_s_ready", s_ready, 1'b0);
    chk("init_vec_zero", vec_out == '0, 1'b1);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", s_ready, 1'b1);

    // clean frame 1..49
    clr();
    for (int i = 0; i < N; i++) send(W'(i + 1), i == N - 1);
    t_last = cyc;
    idle(10);
    chk("clean_vv_count", vv_q.size(), 1);
    chk("clean_vv_time", q0(vv_q), t_last);
    chk("clean_rv_count", rv_q.size(), 1);
    chk("clean_rv_delay", q0(rv_q) - q0(vv_q), 6);
    chk("clean_fe_count", fe_cnt, 0);
    chk("clean_vec0", vec_out[0], 1);
    chk("clean_vec24", vec_out[24], 25);
    chk("clean_vec48", vec_out[48], 49);

    // gapped frame, same values
    clr();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      send(W'(i + 1), i == N - 1);
    end
    t_last = cyc;
    idle(10);
    chk("gap_vv_count", vv_q.size(), 1);
    chk("gap_vv_time", q0(vv_q), t_last);
    chk("gap_vec48", vec_out[48], 49);

    // back-to-back frames A=-5, B=7
    clr();
    for (int i = 0; i < N; i++) send(-32'sd5, i == N - 1);
    for (int i = 0; i < N; i++) begin
      if (i == 20) chk("b2b_holds_a", vec_out[10], 64'hFFFF_FFFB);
      send(32'sd7, i == N - 1);
    end
    idle(10);
    chk("b2b_vv_count", vv_q.size(), 2);
    chk("b2b_vv_spacing", qdiff(vv_q), 49);
    chk("b2b_rv_count", rv_q.size(), 2);
    chk("b2b_rv_spacing", qdiff(rv_q), 49);
    chk("b2b_rv_delay", q0(rv_q) - q0(vv_q), 6);
    chk("b2b_vec0", vec_out[0], 7);

    // early s_last on the 10th sample, then a good frame
    clr();
    for (int i = 0; i < 10; i++) send(W'(300 + i), i == 9);
    idle(3);
    chk("early_fe_count", fe_cnt, 1);
    chk("early_no_vv", vv_q.size(), 0);
    chk("early_vec_held", vec_out[0], 7);
    for (int i = 0; i < N; i++) send(W'(100 + i), i == N - 1);
    idle(3);
    chk("recover_vv_count", vv_q.size(), 1);
    chk("recover_vec0", vec_out[0], 100);
    chk("recover_vec48", vec_out[48], 148);

    // missing s_last on the 49th sample
    clr();
    for (int i = 0; i < N; i++) send(W'(500 + i), 1'b0);
    idle(3);
    chk("missing_fe_count", fe_cnt, 1);
    chk("missing_no_vv", vv_q.size(), 0);
    chk("missing_vec_held", vec_out[48], 148);

    // reset after 20 samples, then a fresh frame
    clr();
    for (int i = 0; i < 20; i++) send(W'(900 + i), 1'b0);
    do_reset(2);
    for (int i = 0; i < N; i++) send(W'(i + 1), i == N - 1);
    idle(3);
    chk("postrst_vv_count", vv_q.size(), 1);
    chk("postrst_vec19", vec_out[19], 20);
    chk("postrst_vec48", vec_out[48], 49);

    // reset 3 cycles after vec_valid: that frame's result never appears
    for (int i = 0; i < N; i++) send(W'(200 + i), i == N - 1);
    clr();
    idle(3);
    do_reset(2);
    idle(12);
    chk("inflight_no_rv", rv_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
